pulpemu_clk_rst_seq: RTL and testbench
======================================

// Module: pulpemu_clk_rst_seq
// PURPOSE
//  Power-up/recovery sequencer for the FPGA emulation top. Watches the clock-manager lock and
//  the board reset button, and drives the BUFGCE enables of the soc/per/cluster clocks. Releases
//  the chip resets in a fixed order: ref+per, then soc, then cluster. On lock loss or button
//  press it re-runs the sequence. Runs in the 125 MHz buffered board-clock domain.
// PARAMETERS
//  LOCK_FILTER   1024  consecutive synced-lock-high cycles required before enabling clocks
//  CLK2RST       16    cycles between clock enable and first reset release
//  STAGGER       8     cycles between successive reset releases, and from last release to RUN
//  DEBOUNCE      16    consecutive synced-button-high cycles that count as a press
//  HOLD          32    cycles resets stay asserted (clocks still running) after a fault
// PORTS
//  clk_i            in   1  125 MHz buffered board clock
//  rstn_i           in   1  async active-low reset
//  locked_i         in   1  clock-manager locked, async; 2-flop synced internally (lock_s)
//  button_i         in   1  board reset button, active-high, async; 2-flop synced (btn_s)
//  per_clk_en_o     out  1  BUFGCE enable, per clock
//  soc_clk_en_o     out  1  BUFGCE enable, soc clock
//  cluster_clk_en_o out  1  BUFGCE enable, cluster clock
//  ref_rstn_o       out  1  active-low reset, ref clock divider + per domain
//  soc_rstn_o       out  1  active-low reset, soc
//  cluster_rstn_o   out  1  active-low reset, cluster
//  ready_o          out  1  sequence complete (state RUN)
//  state_o          out  3  current FSM state encoding, for ILA/debug
//  fault_cnt_o      out  8  saturating count of FAULT entries
// BEHAVIOUR
//  - Clock and reset: one clock clk_i; rstn_i is asynchronous, active-low.
//  - Async reset: state=WAIT_LOCK, cnt=0, every output 0, sync flops 0.
//  - States (encoding): WAIT_LOCK=0, CLK_ON=1, REL_PER=2, REL_SOC=3, REL_CL=4, RUN=5, FAULT=6.
//  - Outputs are registered Moore decodes of the next state, so they change on the same edge as state_o.
//      clk_en (all three) = 1 in states 1..6.
//      ref_rstn = 1 in states 2..5.
//      soc_rstn = 1 in states 3..5.
//      cluster_rstn = 1 in states 4..5.
//      ready = 1 in state 5 only.
//  - cnt is a single 16-bit counter, cleared on every state transition.
//  - WAIT_LOCK: cnt increments when lock_s=1 and clears when lock_s=0.
//      Go to CLK_ON on the edge where lock_s=1 and cnt==LOCK_FILTER-1.
//  - CLK_ON: cnt increments each cycle; go to REL_PER when cnt==CLK2RST-1.
//  - REL_PER, REL_SOC, REL_CL: go to the next state when cnt==STAGGER-1.
//  - RUN: hold indefinitely; cnt stays 0.
//  - Fault condition (states 1..5): lock_s==0, or btn_s has been high for DEBOUNCE consecutive
//      cycles (separate 5-bit debounce counter, cleared whenever btn_s=0).
//      On fault: go to FAULT next edge; fault_cnt_o += 1, saturating at 255.
//      Fault takes priority over any stagger/timeout transition in the same cycle.
//  - FAULT: all rstn outputs 0, clocks stay enabled. After HOLD cycles (cnt==HOLD-1), go to
//      WAIT_LOCK, which gates the clocks off. If the button is still held, stay in WAIT_LOCK
//      until btn_s=0, even if lock is good.
//  - Lock drop in WAIT_LOCK clears the filter counter only; no fault is counted.
//  - rstn_i asserted mid-sequence: immediate async return to the reset values above;
//      fault_cnt_o is cleared.
// TESTING
//  1. locked_i=1 before rstn_i release, button 0 -> edges after release:
//       clk_en=1 at edge 1026; ref_rstn=1 at 1042; soc_rstn=1 at 1050;
//       cluster_rstn=1 at 1058; ready=1 at 1066.
//  2. locked_i glitches low for 1 cycle at filter count 500 -> filter restarts;
//       clk_en delayed by 500+ cycles; fault_cnt_o stays 0.
//  3. In RUN, locked_i low -> 3 edges later state=FAULT, all rstn=0, clk_en=1, fault_cnt=1;
//       after 32 cycles clk_en=0; relock -> full sequence repeats.
//  4. Button pulse of 10 cycles in RUN -> no fault. Button held 16+ cycles -> FAULT.
//       Held for 200 cycles -> remains in WAIT_LOCK until release + 1024-cycle filter.
//  5. Lock loss on the same edge REL_SOC times out -> FAULT entered; soc_rstn never rises.
//  6. 300 forced faults -> fault_cnt_o saturates at 255. rstn_i pulse mid-REL_SOC -> all
//       outputs 0 asynchronously, state_o=0, fault_cnt_o=0.

Source files
------------

// File: rtl/pulpemu_clk_rst_seq.sv
// Power-up/recovery sequencer: filters clock-manager lock, gates the BUFGCE enables and
// releases ref+per, soc and cluster resets in order; re-runs the sequence on lock loss or button press.
`default_nettype none

module pulpemu_clk_rst_seq #(
    parameter int LOCK_FILTER = 1024,
    parameter int CLK2RST     = 16,
    parameter int STAGGER     = 8,
    parameter int DEBOUNCE    = 16,
    parameter int HOLD        = 32
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       locked_i,
    input  logic       button_i,
    output logic       per_clk_en_o,
    output logic       soc_clk_en_o,
    output logic       cluster_clk_en_o,
    output logic       ref_rstn_o,
    output logic       soc_rstn_o,
    output logic       cluster_rstn_o,
    output logic       ready_o,
    output logic [2:0] state_o,
    output logic [7:0] fault_cnt_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        CLK_ON    = 3'd1,
        REL_PER   = 3'd2,
        REL_SOC   = 3'd3,
        REL_CL    = 3'd4,
        RUN       = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [4:0]  deb_cnt;
    logic        lock_meta, lock_s;
    logic        btn_meta, btn_s;
    logic        btn_held;
    logic        fault;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            lock_meta <= locked_i;
            lock_s    <= lock_meta;
            btn_meta  <= button_i;
            btn_s     <= btn_meta;
        end
    end

    // Debounce counter saturates once a press has been recognised.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            deb_cnt <= 5'd0;
        end else if (!btn_s) begin
            deb_cnt <= 5'd0;
        end else if (deb_cnt != 5'(DEBOUNCE)) begin
            deb_cnt <= deb_cnt + 5'd1;
        end
    end

    assign btn_held = (deb_cnt == 5'(DEBOUNCE));
    assign fault    = (state >= CLK_ON) && (state <= RUN) && (!lock_s || btn_held);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        case (state)
            WAIT_LOCK: begin
                // A still-held button blocks the lock filter from progressing.
                if (!lock_s || btn_s) begin
                    cnt_nxt = 16'd0;
                end else if (cnt == 16'(LOCK_FILTER - 1)) begin
                    state_nxt = CLK_ON;
                end
            end
            CLK_ON:  if (cnt == 16'(CLK2RST - 1)) state_nxt = REL_PER;
            REL_PER: if (cnt == 16'(STAGGER - 1)) state_nxt = REL_SOC;
            REL_SOC: if (cnt == 16'(STAGGER - 1)) state_nxt = REL_CL;
            REL_CL:  if (cnt == 16'(STAGGER - 1)) state_nxt = RUN;
            RUN:     cnt_nxt = 16'd0;
            FAULT:   if (cnt == 16'(HOLD - 1)) state_nxt = WAIT_LOCK;
            default: state_nxt = WAIT_LOCK;
        endcase
        if (fault) begin
            state_nxt = FAULT;
        end
        if (state_nxt != state) begin
            cnt_nxt = 16'd0;
        end
    end

    // Outputs decode the next state so they move on the same edge as state_o.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= WAIT_LOCK;
            cnt              <= 16'd0;
            per_clk_en_o     <= 1'b0;
            soc_clk_en_o     <= 1'b0;
            cluster_clk_en_o <= 1'b0;
            ref_rstn_o       <= 1'b0;
            soc_rstn_o       <= 1'b0;
            cluster_rstn_o   <= 1'b0;
            ready_o          <= 1'b0;
            fault_cnt_o      <= 8'd0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            per_clk_en_o     <= (state_nxt >= CLK_ON) && (state_nxt <= FAULT);
            soc_clk_en_o     <= (state_nxt >= CLK_ON) && (state_nxt <= FAULT);
            cluster_clk_en_o <= (state_nxt >= CLK_ON) && (state_nxt <= FAULT);
            ref_rstn_o       <= (state_nxt >= REL_PER) && (state_nxt <= RUN);
            soc_rstn_o       <= (state_nxt >= REL_SOC) && (state_nxt <= RUN);
            cluster_rstn_o   <= (state_nxt >= REL_CL) && (state_nxt <= RUN);
            ready_o          <= (state_nxt == RUN);
            if (fault && (fault_cnt_o != 8'hFF)) begin
                fault_cnt_o <= fault_cnt_o + 8'd1;
            end
        end
    end

    assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_pulpemu_clk_rst_seq.sv
// Directed bench for pulpemu_clk_rst_seq: default-parameter instance for sequencing/fault
// timing, plus a small-parameter instance for fault counter saturation.
`default_nettype none

module tb_pulpemu_clk_rst_seq;

    // {per,soc,cluster clk_en, ref,soc,cluster rstn, ready}
    localparam logic [6:0] O_WAIT = 7'b000_000_0;
    localparam logic [6:0] O_CLK  = 7'b111_000_0;
    localparam logic [6:0] O_PER  = 7'b111_100_0;
    localparam logic [6:0] O_SOC  = 7'b111_110_0;
    localparam logic [6:0] O_CL   = 7'b111_111_0;
    localparam logic [6:0] O_RUN  = 7'b111_111_1;
    localparam logic [6:0] O_FLT  = 7'b111_000_0;

    logic clk = 1'b0;
    logic rstn, locked, button;
    logic rstn_b, locked_b, button_b;

    logic       per_en, soc_en, cl_en, ref_rn, soc_rn, cl_rn, ready;
    logic [2:0] state;
    logic [7:0] fcnt;
    logic       per_en_b, soc_en_b, cl_en_b, ref_rn_b, soc_rn_b, cl_rn_b, ready_b;
    logic [2:0] state_b;
    logic [7:0] fcnt_b;

    int tests = 0;
    int fails = 0;

    always #4 clk = ~clk;

    pulpemu_clk_rst_seq dut (
        .clk_i(clk), .rstn_i(rstn), .locked_i(locked), .button_i(button),
        .per_clk_en_o(per_en), .soc_clk_en_o(soc_en), .cluster_clk_en_o(cl_en),
        .ref_rstn_o(ref_rn), .soc_rstn_o(soc_rn), .cluster_rstn_o(cl_rn),
        .ready_o(ready), .state_o(state), .fault_cnt_o(fcnt)
    );

    pulpemu_clk_rst_seq #(
        .LOCK_FILTER(4), .CLK2RST(4), .STAGGER(2), .DEBOUNCE(4), .HOLD(4)
    ) dut_b (
        .clk_i(clk), .rstn_i(rstn_b), .locked_i(locked_b), .button_i(button_b),
        .per_clk_en_o(per_en_b), .soc_clk_en_o(soc_en_b), .cluster_clk_en_o(cl_en_b),
        .ref_rstn_o(ref_rn_b), .soc_rstn_o(soc_rn_b), .cluster_rstn_o(cl_rn_b),
        .ready_o(ready_b), .state_o(state_b), .fault_cnt_o(fcnt_b)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] st, input logic [6:0] fl);
        check(tag, {6'd0, state, per_en, soc_en, cl_en, ref_rn, soc_rn, cl_rn, ready},
              {6'd0, st, fl});
    endtask

    initial begin
        rstn = 1'b0; locked = 1'b1; button = 1'b0;
        rstn_b = 1'b0; locked_b = 1'b0; button_b = 1'b0;
        #20;
        chk("reset_outputs", 3'd0, O_WAIT);
        check("reset_fcnt", {8'd0, fcnt}, 16'd0);
        check("reset_b_fcnt", {8'd0, fcnt_b}, 16'd0);

        // Lock already good at release: clk_en at edge 1026, releases every 16/8 cycles
        @(negedge clk); rstn = 1'b1;
        step(1025); chk("t1_e1025_wait", 3'd0, O_WAIT);
        step(1);    chk("t1_e1026_clk_on", 3'd1, O_CLK);
        step(15);   chk("t1_e1041_clk_on", 3'd1, O_CLK);
        step(1);    chk("t1_e1042_rel_per", 3'd2, O_PER);
        step(8);    chk("t1_e1050_rel_soc", 3'd3, O_SOC);
        step(8);    chk("t1_e1058_rel_cl", 3'd4, O_CL);
        step(7);    chk("t1_e1065_rel_cl", 3'd4, O_CL);
        step(1);    chk("t1_e1066_run", 3'd5, O_RUN);

        // Short button pulse is filtered out
        button = 1'b1; step(10); button = 1'b0; step(30);
        chk("t4_pulse_run", 3'd5, O_RUN);
        check("t4_pulse_fcnt", {8'd0, fcnt}, 16'd0);

        // Lock loss in RUN
        locked = 1'b0;
        step(2);  chk("t3_e2_run", 3'd5, O_RUN);
        step(1);  chk("t3_e3_fault", 3'd6, O_FLT);
        check("t3_fcnt", {8'd0, fcnt}, 16'd1);
        step(31); chk("t3_hold_end", 3'd6, O_FLT);
        step(1);  chk("t3_wait_lock", 3'd0, O_WAIT);

        // Relock with a one-cycle glitch around filter count 500
        locked = 1'b1; step(502);
        locked = 1'b0; step(1);
        locked = 1'b1;
        step(1025); chk("t2_e1528_wait", 3'd0, O_WAIT);
        step(1);    chk("t2_e1529_clk_on", 3'd1, O_CLK);
        check("t2_fcnt", {8'd0, fcnt}, 16'd1);
        step(40);   chk("t2_run", 3'd5, O_RUN);

        // Button held 200 cycles
        button = 1'b1;
        step(18);  chk("t4_e18_run", 3'd5, O_RUN);
        step(1);   chk("t4_e19_fault", 3'd6, O_FLT);
        check("t4_fcnt", {8'd0, fcnt}, 16'd2);
        step(181); chk("t4_held_wait", 3'd0, O_WAIT);
        button = 1'b0;
        step(1025); chk("t4_e1225_wait", 3'd0, O_WAIT);
        step(1);    chk("t4_e1226_clk_on", 3'd1, O_CLK);
        step(40);   chk("t4_run", 3'd5, O_RUN);

        // Async reset from RUN clears fault counter
        #1 rstn = 1'b0;
        #1 chk("t6_rst_run", 3'd0, O_WAIT);
        check("t6_rst_fcnt", {8'd0, fcnt}, 16'd0);
        @(negedge clk); rstn = 1'b1;
        step(1052); chk("t6_rel_soc", 3'd3, O_SOC);
        #1 rstn = 1'b0;
        #1 chk("t6_rst_rel_soc", 3'd0, O_WAIT);

        // Lock loss lands on the REL_SOC timeout edge
        @(negedge clk); rstn = 1'b1;
        step(1055); chk("t5_e1055_rel_soc", 3'd3, O_SOC);
        locked = 1'b0;
        step(2);  chk("t5_e1057_rel_soc", 3'd3, O_SOC);
        step(1);  chk("t5_e1058_fault", 3'd6, O_FLT);
        check("t5_fcnt", {8'd0, fcnt}, 16'd1);
        step(32); chk("t5_wait_lock", 3'd0, O_WAIT);

        // Fault counter saturation on the fast instance
        @(negedge clk); rstn_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            locked_b = 1'b1; step(10);
            locked_b = 1'b0; step(10);
        end
        check("t6_fcnt_100", {8'd0, fcnt_b}, 16'd100);
        check("t6_state_b_wait", {13'd0, state_b}, 16'd0);
        for (int i = 0; i < 200; i++) begin
            locked_b = 1'b1; step(10);
            locked_b = 1'b0; step(10);
        end
        check("t6_fcnt_sat", {8'd0, fcnt_b}, 16'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
